// File: rtl/fdd_mailbox_ctrl.sv
// ZX<->FDD 6-bit mailbox: synchronised strobes sequence two small FIFOs with per-side status.
// Latency: SYNC_STAGES+1 clocks from strobe edge to FIFO update, one more to registered outputs.
// No backpressure: a push into a full FIFO is dropped and sets a sticky overrun; FDD_MBOX_IRQ_EN adds nFDD_INT.

module fdd_mailbox_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic                   CLK_16MHZ,
  input  logic                   nRESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   ovr_clr,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop at full frees the head slot in the same cycle, so the push is not an overrun.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK_16MHZ) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (push && !do_push) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end
endmodule

// Strobe synchroniser plus edge detector; evt pulses for one cycle when the synced level
// moves to EVT_LVL.
module fdd_mailbox_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0,
  parameter logic EVT_LVL     = 1'b1
) (
  input  logic CLK_16MHZ,
  input  logic nRESET,
  input  logic settled,
  input  logic strobe,
  output logic evt
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
    if (!nRESET) begin
      sync <= {SYNC_STAGES{IDLE}};
      prev <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], strobe};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign evt = settled && (prev != sync[SYNC_STAGES-1]) && (sync[SYNC_STAGES-1] == EVT_LVL);
endmodule

module fdd_mailbox_ctrl #(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_16MHZ,
  input  logic       nRESET,
  input  logic       zx_wr_stb,
  input  logic       zx_rd_stb,
  input  logic [5:0] zx_wdata,
  input  logic       nTIOUT,
  input  logic       nTIIN,
  input  logic [5:0] fdd_wdata,
  output logic [5:0] zx_rdata,
  output logic [5:0] fdd_rdata,
  output logic [2:0] zx_status,
  output logic [2:0] fdd_status,
  output logic       nFDD_INT
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

  logic [2:0]    settle_cnt;
  logic          settled;
  logic          zx_wr_evt;
  logic          zx_rd_evt;
  logic          fdd_wr_evt;
  logic          fdd_rd_evt;
  logic [5:0]    head_a;
  logic [5:0]    head_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          ovr_a;
  logic          ovr_b;

  // Events stay masked until the chains and edge flops hold real samples, so a strobe
  // already active at reset release is absorbed instead of seen as an edge.
  always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
    if (!nRESET) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 3'd1;
    end
  end
  assign settled = (settle_cnt == SETTLE);

  fdd_mailbox_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0), .EVT_LVL(1'b1)) u_zx_wr (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .settled(settled), .strobe(zx_wr_stb), .evt(zx_wr_evt)
  );
  fdd_mailbox_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b0), .EVT_LVL(1'b0)) u_zx_rd (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .settled(settled), .strobe(zx_rd_stb), .evt(zx_rd_evt)
  );
  fdd_mailbox_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1), .EVT_LVL(1'b0)) u_fdd_wr (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .settled(settled), .strobe(nTIOUT), .evt(fdd_wr_evt)
  );
  fdd_mailbox_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE(1'b1), .EVT_LVL(1'b1)) u_fdd_rd (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .settled(settled), .strobe(nTIIN), .evt(fdd_rd_evt)
  );

  // Write data is taken straight off the bus in the event cycle; the strobe is still active.
  fdd_mailbox_fifo #(.DEPTH(DEPTH), .W(6)) u_fifo_a (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET),
    .push(zx_wr_evt), .pop(fdd_rd_evt), .ovr_clr(zx_rd_evt),
    .wdata(zx_wdata), .head(head_a), .count(cnt_a), .ovr(ovr_a)
  );
  fdd_mailbox_fifo #(.DEPTH(DEPTH), .W(6)) u_fifo_b (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET),
    .push(fdd_wr_evt), .pop(zx_rd_evt), .ovr_clr(fdd_rd_evt),
    .wdata(fdd_wdata), .head(head_b), .count(cnt_b), .ovr(ovr_b)
  );

  always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
    if (!nRESET) begin
      zx_rdata   <= '0;
      fdd_rdata  <= '0;
      zx_status  <= '0;
      fdd_status <= '0;
    end else begin
      zx_rdata   <= (cnt_b != '0) ? head_b : 6'h00;
      fdd_rdata  <= (cnt_a != '0) ? head_a : 6'h00;
      zx_status  <= {ovr_a, cnt_a == FULL, cnt_b != '0};
      fdd_status <= {ovr_b, cnt_b == FULL, cnt_a != '0};
    end
  end

`ifdef FDD_MBOX_IRQ_EN
  logic irq_n;

  always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
    if (!nRESET) begin
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~(fdd_status[0] | fdd_status[2]);
    end
  end
  assign nFDD_INT = irq_n;
`else
  assign nFDD_INT = 1'b1;
`endif
endmodule

// File: tb/tb_fdd_mailbox_ctrl.sv
// Randomised mailbox bench: strobe transactions checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fdd_mailbox_ctrl;
  localparam int DEPTH       = 2;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic       CLK_16MHZ = 1'b0;
  logic       nRESET    = 1'b0;
  logic       zx_wr_stb = 1'b0;
  logic       zx_rd_stb = 1'b0;
  logic       nTIOUT    = 1'b1;
  logic       nTIIN     = 1'b1;
  logic [5:0] zx_wdata  = 6'h00;
  logic [5:0] fdd_wdata = 6'h00;
  logic [5:0] zx_rdata;
  logic [5:0] fdd_rdata;
  logic [2:0] zx_status;
  logic [2:0] fdd_status;
  logic       nFDD_INT;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per direction plus the sticky overrun flags.
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  bit         ovr_a = 1'b0;
  bit         ovr_b = 1'b0;

  fdd_mailbox_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET),
    .zx_wr_stb(zx_wr_stb), .zx_rd_stb(zx_rd_stb), .zx_wdata(zx_wdata),
    .nTIOUT(nTIOUT), .nTIIN(nTIIN), .fdd_wdata(fdd_wdata),
    .zx_rdata(zx_rdata), .fdd_rdata(fdd_rdata),
    .zx_status(zx_status), .fdd_status(fdd_status), .nFDD_INT(nFDD_INT)
  );

  always #31.25 CLK_16MHZ = ~CLK_16MHZ;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_16MHZ);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [5:0] ea;
    logic [5:0] eb;
    logic       eint;
    ea = 6'h00;
    eb = 6'h00;
    if (qa.size() != 0) ea = qa[0];
    if (qb.size() != 0) eb = qb[0];
`ifdef FDD_MBOX_IRQ_EN
    eint = !((qa.size() != 0) || ovr_b);
`else
    eint = 1'b1;
`endif
    chk_val({tag, "/zx_status"},  zx_status,  {ovr_a, qa.size() == DEPTH, qb.size() != 0});
    chk_val({tag, "/fdd_status"}, fdd_status, {ovr_b, qb.size() == DEPTH, qa.size() != 0});
    chk_val({tag, "/zx_rdata"},   zx_rdata,   eb);
    chk_val({tag, "/fdd_rdata"},  fdd_rdata,  ea);
    chk_val({tag, "/nFDD_INT"},   nFDD_INT,   eint);
  endtask

  // Write strobes corrupt the bus once the sampling window has passed.
  task automatic zx_write(input logic [5:0] d);
    zx_wdata = d; zx_wr_stb = 1'b1;
    cyc(SYNC_STAGES + 1); zx_wdata = ~d;
    cyc(3); zx_wr_stb = 1'b0;
    cyc(6);
    if (qa.size() == DEPTH) ovr_a = 1'b1;
    else qa.push_back(d);
  endtask

  task automatic fdd_write(input logic [5:0] d);
    fdd_wdata = d; nTIOUT = 1'b0;
    cyc(SYNC_STAGES + 1); fdd_wdata = ~d;
    cyc(3); nTIOUT = 1'b1;
    cyc(6);
    if (qb.size() == DEPTH) ovr_b = 1'b1;
    else qb.push_back(d);
  endtask

  task automatic zx_read(input int hold, input bit every);
    logic [5:0] eb;
    eb = 6'h00;
    if (qb.size() != 0) eb = qb[0];
    zx_rd_stb = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      if (every || i == hold - 1) chk_val("zx_rd_hold", zx_rdata, eb);
    end
    zx_rd_stb = 1'b0;
    cyc(6);
    if (qb.size() != 0) void'(qb.pop_front());
    ovr_a = 1'b0;
  endtask

  task automatic fdd_read();
    logic [5:0] ea;
    ea = 6'h00;
    if (qa.size() != 0) ea = qa[0];
    nTIIN = 1'b0;
    cyc(6);
    chk_val("fdd_rd_hold", fdd_rdata, ea);
    nTIIN = 1'b1;
    cyc(6);
    if (qa.size() != 0) void'(qa.pop_front());
    ovr_b = 1'b0;
  endtask

  // ZX write leading edge coincides with FDD read trailing edge.
  task automatic zxw_fddr(input logic [5:0] d);
    nTIIN = 1'b0;
    cyc(6);
    zx_wdata = d; zx_wr_stb = 1'b1; nTIIN = 1'b1;
    cyc(SYNC_STAGES + 1); zx_wdata = ~d;
    cyc(3); zx_wr_stb = 1'b0;
    cyc(6);
    if (qa.size() != 0) void'(qa.pop_front());
    qa.push_back(d);
    ovr_b = 1'b0;
  endtask

  task automatic fddw_zxr(input logic [5:0] d);
    zx_rd_stb = 1'b1;
    cyc(6);
    fdd_wdata = d; nTIOUT = 1'b0; zx_rd_stb = 1'b0;
    cyc(SYNC_STAGES + 1); fdd_wdata = ~d;
    cyc(3); nTIOUT = 1'b1;
    cyc(6);
    if (qb.size() != 0) void'(qb.pop_front());
    qb.push_back(d);
    ovr_a = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(4);
    check_all("reset");
    nRESET = 1'b1;
    cyc(5);
    check_all("post_reset");

    // Output latency of a single ZX write.
    zx_wdata = 6'h2A; zx_wr_stb = 1'b1;
    cyc(LAT - 1);
    chk_val("lat_early", fdd_status, 3'b000);
    cyc(1);
    chk_val("lat_status", fdd_status, 3'b001);
    chk_val("lat_data", fdd_rdata, 6'h2A);
`ifdef FDD_MBOX_IRQ_EN
    chk_val("irq_early", nFDD_INT, 1'b1);
    cyc(1);
    chk_val("irq_assert", nFDD_INT, 1'b0);
`endif
    zx_wr_stb = 1'b0;
    cyc(6);
    qa.push_back(6'h2A);
    check_all("first_write");
    fdd_read();
    check_all("first_drain");

    // Overrun of FIFO A.
    zx_write(6'h01); zx_write(6'h02); zx_write(6'h03);
    chk_val("ovr_zx_status", zx_status, 3'b110);
    check_all("ovr_a");
    fdd_read(); fdd_read();
    check_all("ovr_drain");
    zx_read(6, 1'b0);
    check_all("ovr_a_clear");

    // Push and pop in the same cycle at full.
    zx_write(6'h11); zx_write(6'h12);
    zxw_fddr(6'h13);
    chk_val("full_pushpop_status", zx_status, 3'b010);
    check_all("full_pushpop");
    fdd_read(); fdd_read();
    check_all("full_pushpop_drain");

    // FDD -> ZX with a long ZX read access.
    fdd_write(6'h15);
    chk_val("b_avail", zx_status, 3'b001);
    zx_read(10, 1'b1);
    check_all("long_read");

    fdd_read();
    check_all("empty_pop");

    // Reset in the middle of an FDD write, strobe held across release.
    zx_write(6'h3C);
    fdd_wdata = 6'h2B; nTIOUT = 1'b0;
    cyc(1);
    nRESET = 1'b0;
    #1;
    qa.delete(); qb.delete(); ovr_a = 1'b0; ovr_b = 1'b0;
    check_all("mid_reset");
    cyc(2);
    nRESET = 1'b1;
    cyc(10);
    check_all("held_strobe");
    nTIOUT = 1'b1;
    cyc(6);
    fdd_write(6'h2B);
    check_all("after_toggle");

    for (int i = 0; i < 160; i++) begin
      int unsigned op;
      logic [5:0] d;
      op = $urandom_range(0, 5);
      d  = 6'($urandom);
      case (op)
        0: zx_write(d);
        1: fdd_write(d);
        2: zx_read(6, 1'b0);
        3: fdd_read();
        4: zxw_fddr(d);
        default: fddw_zxr(d);
      endcase
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fdd_mailbox_ctrl.md
# fdd_mailbox_ctrl

Synchronous controller for the 6-bit ZX↔FDD mailbox, clocked from the 16 MHz master clock. It sits between the asynchronous I/O strobes (ZX port read/write decode, FDD nTIIN/nTIOUT) and the data paths that replace the two LS273/LS244 pairs. It sequences both transfer directions through small FIFOs and provides per-side availability, full and overrun status. It can optionally raise an interrupt to the FDD Z80.

## Interface
- DEPTH, 2, entries per direction FIFO; power of two, 1..8
- SYNC_STAGES, 2, synchronizer flops per async strobe; 2..3
- CLK_16MHZ  in  1  master clock, all state on rising edge
- nRESET  in  1  asynchronous, active-low reset
- zx_wr_stb  in  1  async, active high: ZX I/O write to mailbox port
- zx_rd_stb  in  1  async, active high: ZX I/O read from mailbox port
- zx_wdata  in  6  ZX bus bits {D7,D6,D5,D4,D1,D0}
- nTIOUT  in  1  async, active low: FDD write strobe
- nTIIN  in  1  async, active low: FDD read strobe
- fdd_wdata  in  6  FDD bus bits, same ordering
- zx_rdata  out  6  head of FDD→ZX FIFO (B)
- fdd_rdata  out  6  head of ZX→FDD FIFO (A)
- zx_status  out  3  {ovr_a, a_full, b_avail}
- fdd_status  out  3  {ovr_b, b_full, a_avail}
- nFDD_INT  out  1  active-low interrupt to FDD Z80

## Operation
- Each strobe passes through SYNC_STAGES flops, then an edge detector on the synchronized level. Each edge produces a one-cycle event.
- Write events (zx_wr_stb rising, nTIOUT falling) occur at the leading edge. Data is sampled in that same cycle while the strobe is still active.
- Read events (zx_rd_stb falling, nTIIN rising) occur at the trailing edge. The head entry stays stable for the whole read access and is popped afterwards.
- FIFO A (ZX→FDD):
  - A push occurs on a ZX write event.
  - A pop occurs on an FDD read event.
- FIFO B (FDD→ZX):
  - A push occurs on an FDD write event.
  - A pop occurs on a ZX read event.
- Count width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- Push when count==DEPTH with no simultaneous pop:
  - The data is discarded.
  - The sticky ovr_x flag of that direction is set.
  - The count is unchanged.
- Pop when count==0: ignored. Pointers, count and flags are unchanged.
- Push and pop in the same cycle:
  - If count>0, both take effect and the count is unchanged. At full this case is not an overrun.
  - If count==0, the push is accepted and the pop is ignored, so the count becomes 1.
- ovr_a is cleared by a ZX read event. ovr_b is cleared by an FDD read event. When a set and a clear coincide, set wins.
- x_avail = count_x!=0. x_full = count_x==DEPTH.
- zx_rdata/fdd_rdata equal the head entry when avail, else 6'h00.
- Bit 5 of FIFO A is carried unchanged. Replacing FDD D7 with WD1770 DRQ happens downstream, not here.

## Timing
- Reset values:
  - All counts, pointers and ovr flags: 0.
  - zx_rdata, fdd_rdata: 0. zx_status, fdd_status: 0.
  - nFDD_INT: 1.
  - Synchronizers are reset to the inactive level, so no spurious event is generated after release.
- Event latency: SYNC_STAGES+1 clocks from the async edge to the event cycle.
- Status and data outputs are registered and update the clock after the event. Total latency from async edge to output is SYNC_STAGES+2 clocks (4 at default).
- Minimum strobe active and inactive width: SYNC_STAGES+2 clocks (250 ns at default). A Z80 I/O cycle at 3.5 MHz or 4 MHz satisfies this.
- Write data must be stable from strobe assertion until SYNC_STAGES+1 clocks after it.
- Reset asserted mid-transfer clears all state immediately. A strobe still active at reset release does not generate an event until it next toggles.

## Configuration
- FDD_MBOX_IRQ_EN defined:
  - nFDD_INT is a registered copy of ~(a_avail | ovr_b).
  - It asserts one clock after status updates.
  - It deasserts one clock after the condition clears.
- FDD_MBOX_IRQ_EN undefined: nFDD_INT is tied to 1'b1 and no interrupt logic is synthesized.

## Test plan
- Reset, then a ZX write of 6'h2A → after 4 clocks fdd_status=3'b001 and fdd_rdata=6'h2A. With IRQ_EN, nFDD_INT=0 one clock later.
- DEPTH=2: three ZX writes 6'h01, 6'h02, 6'h03 with no FDD read → zx_status=3'b110. Two FDD reads then return 01, 02; 03 is lost.
- With A full, ZX write and FDD read trailing edge in the same event cycle → count stays 2, ovr_a stays 0, and the new entry is placed at the tail.
- FDD writes 6'h15 → zx_status=3'b001. zx_rdata=6'h15 is held through a 10-clock ZX read, then after its trailing edge zx_rdata=0 and b_avail=0.
- FDD read on an empty FIFO A → no state change and fdd_rdata=0. Then assert nRESET mid-write with nTIOUT held low → no push after release until nTIOUT toggles.
